// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with a double-buffered frame.
// Digit slots open with a short all-anodes-off window to hide ghosting.
module seg_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500,
   parameter bit HEX_EN      = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_d;
   logic [4*NUM_DIGITS-1:0] act_d;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   act_dp;
   logic                    pend_v;

   logic                    tick;
   logic                    bnd;
   logic [NUM_DIGITS-1:0]   lzb;
   logic                    nz;
   logic [3:0]              cur;
   logic [6:0]              seg_nxt;

   function automatic logic [6:0] dec(input logic [3:0] c);
      logic [6:0] r;
      unique case (c)
         4'h0: r = 7'b0000001;
         4'h1: r = 7'b1001111;
         4'h2: r = 7'b0010010;
         4'h3: r = 7'b0000110;
         4'h4: r = 7'b1001100;
         4'h5: r = 7'b0100100;
         4'h6: r = 7'b0100000;
         4'h7: r = 7'b0001111;
         4'h8: r = 7'b0000000;
         4'h9: r = 7'b0000100;
         4'ha: r = HEX_EN ? 7'b0001000 : 7'b1111111;
         4'hb: r = HEX_EN ? 7'b1100000 : 7'b1111111;
         4'hc: r = HEX_EN ? 7'b0110001 : 7'b1111111;
         4'hd: r = HEX_EN ? 7'b1000010 : 7'b1111111;
         4'he: r = HEX_EN ? 7'b0110000 : 7'b1111111;
         4'hf: r = HEX_EN ? 7'b0111000 : 7'b1111111;
      endcase
      return r;
   endfunction

   assign tick = (presc == PW'(REFRESH_DIV - 1));
   assign bnd  = tick && (idx == IW'(NUM_DIGITS - 1));

   // Scan from the top digit down; a digit blanks until a nonzero one is seen.
   always_comb begin
      lzb = '0;
      nz  = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz     = nz | (act_d[4*i +: 4] != 4'd0);
         lzb[i] = blank_lz & ~nz & (i != 0);
      end
   end

   assign cur     = act_d[4*idx +: 4];
   assign seg_nxt = lzb[idx] ? 7'b1111111 : dec(cur);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= '0;
         pend_d     <= '0;
         pend_dp    <= '0;
         pend_v     <= 1'b0;
         act_d      <= '0;
         act_dp     <= '0;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         if (en) begin
            presc      <= tick ? '0 : presc + 1'b1;
            if (tick)
               idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            frame_done <= bnd;
            an         <= (presc >= PW'(BLANK_CYC))
                          ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg        <= seg_nxt;
            dp         <= ~act_dp[idx];
            if (bnd && pend_v) begin
               act_d  <= pend_d;
               act_dp <= pend_dp;
               pend_v <= 1'b0;
            end
         end else begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            if (pend_v) begin
               act_d  <= pend_d;
               act_dp <= pend_dp;
            end
         end
         // A same-cycle load always leaves fresh data pending.
         if (load) begin
            pend_d  <= digits_in;
            pend_dp <= dp_in;
            pend_v  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-time reference model plus directed
// literal checks, then randomized loads, enables and blanking.
module tb_seg_scan_driver;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int BLK = 1;
   localparam int FR  = N * DIV;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        blank_lz;

   logic [6:0]  seg1, seg0;
   logic        dp1, dp0;
   logic [3:0]  an1, an0;
   logic        fd1, fd0;

   seg_scan_driver #(
      .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLK), .HEX_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load),
      .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
      .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
   );

   seg_scan_driver #(
      .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLK), .HEX_EN(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load),
      .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
      .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
   endtask

   logic [6:0] gl [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic [15:0] m_pend_d, m_act_d;
   logic [3:0]  m_pend_dp, m_act_dp;
   bit          m_pv;
   int          t;
   int          slot, pos;
   bit          bnd;
   logic [3:0]  e_an;
   logic [6:0]  e_seg1, e_seg0;
   logic        e_dp, e_fd;

   function automatic logic [6:0] glyph(input int s, input bit hx);
      logic [15:0] up;
      logic [3:0]  c;
      up = m_act_d >> (4 * s);
      c  = up[3:0];
      if (blank_lz && s > 0 && up == 16'h0) return 7'h7f;
      if (c > 4'd9 && !hx) return 7'h7f;
      return gl[c];
   endfunction

   // t counts enabled cycles since the scan (re)started; slot and
   // position fall out of it by division.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend_d = '0; m_pend_dp = '0; m_pv = 1'b0;
         m_act_d = '0; m_act_dp = '0; t = 0;
         e_an = 4'hf; e_seg1 = 7'h7f; e_seg0 = 7'h7f;
         e_dp = 1'b1; e_fd = 1'b0;
      end else begin
         if (en) begin
            slot   = (t / DIV) % N;
            pos    = t % DIV;
            e_an   = (pos >= BLK) ? ~(4'b0001 << slot) : 4'hf;
            e_seg1 = glyph(slot, 1'b1);
            e_seg0 = glyph(slot, 1'b0);
            e_dp   = ~m_act_dp[slot];
            bnd    = (t % FR) == FR - 1;
            e_fd   = bnd;
            if (bnd && m_pv) begin
               m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_pv = 1'b0;
            end
            t++;
         end else begin
            e_an = 4'hf; e_seg1 = 7'h7f; e_seg0 = 7'h7f;
            e_dp = 1'b1; e_fd = 1'b0;
            if (m_pv) begin
               m_act_d = m_pend_d; m_act_dp = m_pend_dp;
            end
            t = 0;
         end
         if (load) begin
            m_pend_d = digits_in; m_pend_dp = dp_in; m_pv = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         chk("an", 32'(an1), 32'(e_an));
         chk("seg", 32'(seg1), 32'(e_seg1));
         chk("dp", 32'(dp1), 32'(e_dp));
         chk("frame_done", 32'(fd1), 32'(e_fd));
         chk("an_hex0", 32'(an0), 32'(e_an));
         chk("seg_hex0", 32'(seg0), 32'(e_seg0));
         chk("dp_hex0", 32'(dp0), 32'(e_dp));
         chk("fd_hex0", 32'(fd0), 32'(e_fd));
      end
   end

   task automatic wait_fd(input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (fd1) begin
            got = 1'b1;
            break;
         end
      end
      chk("wait_frame_done", 32'(got), 32'd1);
   endtask

   // Entered on the cycle frame_done is visible; literal slot values.
   task automatic run_frame(input logic [27:0] e1, input logic [27:0] e0,
                            input logic [3:0] edp);
      logic [15:0] an_tab;
      logic        b;
      int          s;
      an_tab = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         load = 1'b0;
         s = k / DIV;
         if (k % DIV == 0) begin
            b = ~edp[s];
            chk("lit_an_blank", 32'(an1), 32'hf);
            chk("lit_seg", 32'(seg1), 32'(e1[7*s +: 7]));
            chk("lit_seg_hex0", 32'(seg0), 32'(e0[7*s +: 7]));
            chk("lit_dp", 32'(dp1), 32'(b));
         end
         if (k % DIV == 1)
            chk("lit_an_slot", 32'(an1), 32'(an_tab[4*s +: 4]));
      end
      chk("lit_frame_done", 32'(fd1), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; load = 1'b0;
      digits_in = '0; dp_in = '0; blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_an", 32'(an1), 32'hf);
      chk("rst_seg", 32'(seg1), 32'h7f);
      chk("rst_dp", 32'(dp1), 32'd1);
      chk("rst_fd", 32'(fd1), 32'd0);

      rst_n = 1'b1; chk_on = 1'b1; en = 1'b1;
      load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0101;
      wait_fd(40);
      run_frame({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                4'b0101);

      repeat (5) @(negedge clk);
      load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000;
      @(negedge clk); load = 1'b0;
      repeat (3) @(negedge clk);
      load = 1'b1; digits_in = 16'h5678; dp_in = 4'b0000;
      @(negedge clk); load = 1'b0;
      wait_fd(16);
      run_frame({7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
                {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
                4'b0000);

      repeat (15) @(negedge clk);
      load = 1'b1; digits_in = 16'h0009; dp_in = 4'b0000;
      @(negedge clk); load = 1'b0;
      chk("bnd_load_fd", 32'(fd1), 32'd1);
      run_frame({7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
                {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
                4'b0000);

      blank_lz = 1'b1;
      load = 1'b1; digits_in = 16'h00a0; dp_in = 4'b0010;
      run_frame({7'h7f, 7'h7f, 7'h7f, 7'b0000100},
                {7'h7f, 7'h7f, 7'h7f, 7'b0000100}, 4'b0000);
      run_frame({7'h7f, 7'h7f, 7'b0001000, 7'b0000001},
                {7'h7f, 7'h7f, 7'h7f, 7'b0000001}, 4'b0010);

      repeat (5) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("en_off_an", 32'(an1), 32'hf);
      chk("en_off_seg", 32'(seg1), 32'h7f);
      repeat (3) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      chk("en_on_blank", 32'(an1), 32'hf);
      @(negedge clk);
      chk("en_on_digit0", 32'(an1), 32'he);

      load = 1'b1; digits_in = 16'h8888; dp_in = 4'hf;
      @(posedge clk);
      #2 rst_n = 1'b0; load = 1'b0;
      #1;
      chk("midrst_an", 32'(an1), 32'hf);
      chk("midrst_seg", 32'(seg1), 32'h7f);
      chk("midrst_dp", 32'(dp1), 32'd1);
      chk("midrst_fd", 32'(fd1), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         load      = ($urandom % 8) == 0;
         digits_in = 16'($urandom);
         dp_in     = 4'($urandom);
         if ($urandom % 50 == 0) blank_lz = ~blank_lz;
         if ($urandom % 150 == 0) en = ~en;
      end
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display, parametrised in digit count, refresh rate and anti-ghost blanking.
- Holds a double-buffered digit frame and scans one digit per refresh slot.
- Decodes each nibble to segments, with optional hex glyphs, leading-zero suppression and per-digit decimal point.
- Sits between the binary-to-BCD converter and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>=2).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < REFRESH_DIV).
- HEX_EN, 1, 1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 show blank.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- en  in  1  display enable.
- load  in  1  one-cycle strobe; captures digits_in/dp_in into the pending buffer.
- digits_in  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low when active.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - seg=7'b1111111, dp=1, an all 1s, frame_done=0.
  - Prescaler=0, digit index=0.
  - Pending buffer, active buffer and pending_valid all 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while en=1; tick when it equals REFRESH_DIV-1.
  - On tick, the prescaler wraps to 0 and the index advances, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary: the tick with index=NUM_DIGITS-1.
  - If pending_valid=1, active <= pending and pending_valid clears.
  - frame_done pulses high the cycle after the boundary.
- load:
  - pending <= {digits_in, dp_in} and pending_valid <= 1.
  - If load coincides with a boundary, active takes the old pending (only if pending_valid was already 1), and the new data stays pending with pending_valid=1.
  - A later load before the boundary overwrites pending; the last load wins.
- Decode, active-low, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - With HEX_EN=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - With HEX_EN=0: 10-15 give 1111111.
- Leading-zero blanking (blank_lz=1):
  - Digit i shows 1111111 if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp is independent of blanking.
- Outputs are registered, one cycle after the prescaler/index state:
  - an[index]=0 only when prescaler >= BLANK_CYC; otherwise all 1s.
  - seg/dp carry the current index's decode throughout the slot.
- en=0:
  - Prescaler and index are held at 0; an, seg and dp are all 1s.
  - load is still accepted; pending is copied to active every cycle while pending_valid=1.
  - When en returns to 1, scanning restarts at digit 0 with prescaler 0.
- Reset mid-frame: immediate return to reset values; any pending data is lost.

Test Plan:
- Reset check, NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, en=1: hold rst_n=0 mid-count -> an=4'b1111, seg=7'b1111111, dp=1 asynchronously.
- Scan order and blanking: load 16'h1234 -> after the first boundary, an follows 1110,1101,1011,0111 with a 1111 cycle at each slot start; seg=1001100, 0000110, 0010010, 1001111 respectively; frame_done pulses every 16 cycles.
- Double buffer: load 16'h1234 and then 16'h5678 in the middle of the same frame -> the display keeps its current frame, then shows 5678 after the boundary; 1234 is never displayed.
- Load on boundary cycle: load 16'h0009 exactly on a boundary tick with pending_valid=0 -> active is unchanged this frame; 0009 appears on the next frame.
- Leading zeros and hex: digits 16'h00A0, blank_lz=1, HEX_EN=1 -> digits 3 and 2 show 1111111, digit 1 shows 0001000, digit 0 shows 0000001. With HEX_EN=0, digit 1 shows 1111111.
- en toggle: drop en mid-slot -> next cycle an=1111. Raise en -> digit 0 slot begins, with an[0]=0 after BLANK_CYC+1 cycles.
